// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predict unit and its history table.
package branch_pkg;

    typedef enum logic [1:0] {
        CT_NONE   = 2'b00,
        CT_BRANCH = 2'b01,
        CT_JAL    = 2'b10,
        CT_JALR   = 2'b11
    } ctrl_transfer_t;

    // Redirect target while halted: fetch parks on an address nothing lives at.
    localparam logic [31:0] HALT_PC   = 32'hFFFF_FFFF;
    localparam logic [31:0] JALR_MASK = 32'hFFFF_FFFE;
    localparam logic [31:0] INSN_BYTES = 32'd4;

    // Weak-taken is 10..0 (MSB set, rest clear): the first counter value that predicts taken.
    function automatic int unsigned ctr_weak_taken(input int unsigned bits);
        return 32'd1 << (bits - 1);
    endfunction

    // Weak-not-taken is 01..1: the last counter value that predicts not-taken.
    function automatic int unsigned ctr_weak_not_taken(input int unsigned bits);
        return (32'd1 << (bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Direct-mapped branch history table: combinational IF read port, synchronous EX update port.
module bht_table
    import branch_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int IDX_W    = $clog2(ENTRIES),
    parameter int TAG_W    = 3,
    parameter int CTR_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              rd_hit,
    output logic              rd_taken,
    output logic [31:0]       rd_target,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              wr_taken,
    input  logic [31:0]       wr_target
);

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [31:0]         target;
        logic [CTR_BITS-1:0] ctr;
    } bht_entry_t;

    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(ctr_weak_taken(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_weak_not_taken(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

    localparam bht_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

    bht_entry_t bht_q [ENTRIES];
    bht_entry_t rd_entry;
    bht_entry_t wr_cur;
    bht_entry_t wr_next;
    logic       wr_hit;

    // IF read port: straight from the registered table, no bypass of a same-cycle write.
    always_comb begin
        rd_entry  = bht_q[rd_idx];
        rd_hit    = rd_entry.valid && (rd_entry.tag == rd_tag);
        rd_taken  = rd_entry.ctr[CTR_BITS-1];
        rd_target = rd_entry.target;
    end

    // Next value of the entry addressed by EX: allocate on miss, train counter on hit.
    always_comb begin
        wr_cur  = bht_q[wr_idx];
        wr_hit  = wr_cur.valid && (wr_cur.tag == wr_tag);
        wr_next = wr_cur;
        if (!wr_hit) begin
            wr_next.valid  = 1'b1;
            wr_next.tag    = wr_tag;
            wr_next.target = wr_target;
            wr_next.ctr    = wr_taken ? CTR_WT : CTR_WNT;
        end else if (wr_taken) begin
            wr_next.target = wr_target;
            if (wr_cur.ctr != CTR_MAX) begin
                wr_next.ctr = wr_cur.ctr + CTR_ONE;
            end
        end else begin
            if (wr_cur.ctr != CTR_MIN) begin
                wr_next.ctr = wr_cur.ctr - CTR_ONE;
            end
        end
    end

    // Table storage; reset clears every entry and beats a same-cycle update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= RESET_ENTRY;
            end
        end else if (wr_en) begin
            bht_q[wr_idx] <= wr_next;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch unit: IF-stage prediction from the BHT, EX-stage resolution with same-cycle
// redirect on mispredict, sticky halt and a saturating mispredict counter.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int PC_WIDTH    = 9,
    parameter int BHT_ENTRIES = 16,
    parameter int CTR_BITS    = 2,
    parameter int STAT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic                  pred_taken,
    output logic [31:0]           pred_target,
    input  logic                  ex_valid,
    input  logic [PC_WIDTH-1:0]   ex_pc,
    input  logic [31:0]           ex_imm,
    input  logic [1:0]            ex_ctrl_transfer,
    input  logic [31:0]           ex_alu_result,
    input  logic                  ex_pred_taken,
    input  logic [31:0]           ex_pred_target,
    input  logic                  halt,
    output logic                  redirect,
    output logic [31:0]           redirect_pc,
    output logic [31:0]           pc_plus_4,
    output logic                  halted,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX_W - 2;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

    ctrl_transfer_t ct;
    logic [31:0]    if_pc_ext;
    logic [31:0]    ex_pc_ext;
    logic           rd_hit;
    logic           rd_taken;
    logic [31:0]    rd_target;
    logic           act_taken;
    logic [31:0]    act_target;
    logic [31:0]    act_next;
    logic           mispredict;
    logic           halt_active;
    logic           upd_en;

    assign ct        = ctrl_transfer_t'(ex_ctrl_transfer);
    assign if_pc_ext = {{(32-PC_WIDTH){1'b0}}, if_pc};
    assign ex_pc_ext = {{(32-PC_WIDTH){1'b0}}, ex_pc};

    bht_table #(
        .ENTRIES  (BHT_ENTRIES),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W),
        .CTR_BITS (CTR_BITS)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (if_pc[IDX_W+1:2]),
        .rd_tag    (if_pc[PC_WIDTH-1:IDX_W+2]),
        .rd_hit    (rd_hit),
        .rd_taken  (rd_taken),
        .rd_target (rd_target),
        .wr_en     (upd_en),
        .wr_idx    (ex_pc[IDX_W+1:2]),
        .wr_tag    (ex_pc[PC_WIDTH-1:IDX_W+2]),
        .wr_taken  (act_taken),
        .wr_target (act_target)
    );

    // IF prediction: only a tag-matching entry with a taken-leaning counter predicts taken.
    always_comb begin
        pred_taken  = rd_hit && rd_taken;
        pred_target = pred_taken ? rd_target : (if_pc_ext + INSN_BYTES);
    end

    // EX resolution of the actual outcome and target.
    always_comb begin
        pc_plus_4  = ex_pc_ext + INSN_BYTES;
        act_taken  = 1'b0;
        act_target = ex_pc_ext + ex_imm;
        case (ct)
            CT_BRANCH: act_taken = ex_alu_result[0];
            CT_JAL:    act_taken = 1'b1;
            CT_JALR: begin
                act_taken  = 1'b1;
                act_target = ex_alu_result & JALR_MASK;
            end
            default:   act_taken = 1'b0;
        endcase
        act_next = act_taken ? act_target : pc_plus_4;
    end

    // Mispredict detection and redirect mux; halt overrides everything.
    // A non-control instruction only matters if IF wrongly predicted it taken (false hit).
    always_comb begin
        halt_active = halt || halted;
        mispredict  = ex_valid && ((ct != CT_NONE) || ex_pred_taken) &&
                      ((act_taken != ex_pred_taken) ||
                       (act_taken && (act_target != ex_pred_target)));
        redirect    = halt_active || mispredict;
        redirect_pc = halt_active ? HALT_PC : act_next;
        upd_en      = ex_valid && (ct != CT_NONE) && !halt_active;
    end

    // Sticky halt flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            halted <= 1'b0;
        end else if (halt) begin
            halted <= 1'b1;
        end
    end

    // Saturating mispredict statistics, frozen while halting.
    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_count <= '0;
        end else if (mispredict && !halt_active && (mispredict_count != STAT_MAX)) begin
            mispredict_count <= mispredict_count + STAT_ONE;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench: directed vector table, counter saturation run, randomized run vs model.
module tb_branch_predict_unit;

    localparam int PCW = 9;
    localparam int SW  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [PCW-1:0]  if_pc;
    logic            pred_taken;
    logic [31:0]     pred_target;
    logic            ex_valid;
    logic [PCW-1:0]  ex_pc;
    logic [31:0]     ex_imm;
    logic [1:0]      ex_ctrl_transfer;
    logic [31:0]     ex_alu_result;
    logic            ex_pred_taken;
    logic [31:0]     ex_pred_target;
    logic            halt;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic [31:0]     pc_plus_4;
    logic            halted;
    logic [SW-1:0]   mispredict_count;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .PC_WIDTH(PCW), .BHT_ENTRIES(16), .CTR_BITS(2), .STAT_WIDTH(SW)
    ) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_ctrl_transfer(ex_ctrl_transfer), .ex_alu_result(ex_alu_result),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .halt(halt),
        .redirect(redirect), .redirect_pc(redirect_pc), .pc_plus_4(pc_plus_4),
        .halted(halted), .mispredict_count(mispredict_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, hlt_in, ev, ept, chk, e_pt, e_redir, e_halted;
        logic [31:0] ifpc, expc, imm, alu, eptg, e_ptg, e_rpc;
        logic [1:0]  ctrl;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic hl, input int unsigned ifpc,
                                input logic ev, input int unsigned ctrl, input int unsigned expc,
                                input int unsigned imm, input int unsigned alu, input logic ept,
                                input int unsigned eptg, input logic chk, input logic pt,
                                input int unsigned ptg, input logic rd, input int unsigned rpc,
                                input int unsigned cnt, input logic hd);
        vec_t v;
        v.rst = rst; v.hlt_in = hl; v.ifpc = ifpc; v.ev = ev; v.ctrl = 2'(ctrl);
        v.expc = expc; v.imm = imm; v.alu = alu; v.ept = ept; v.eptg = eptg;
        v.chk = chk; v.e_pt = pt; v.e_ptg = ptg; v.e_redir = rd; v.e_rpc = rpc;
        v.e_cnt = 4'(cnt); v.e_halted = hd;
        return v;
    endfunction

    function automatic vec_t idle(input int unsigned ifpc, input logic pt, input int unsigned ptg,
                                  input logic rd, input int unsigned cnt, input logic hd);
        return mk(0, 0, ifpc, 0, 0, 0, 0, 0, 0, 0, 1, pt, ptg, rd, 32'hFFFF_FFFF, cnt, hd);
    endfunction

    task automatic drive(input logic rst, input logic hl, input int unsigned ifpc, input logic ev,
                         input int unsigned ctrl, input int unsigned expc, input int unsigned imm,
                         input int unsigned alu, input logic ept, input int unsigned eptg);
        reset = rst; halt = hl; if_pc = PCW'(ifpc); ex_valid = ev;
        ex_ctrl_transfer = 2'(ctrl); ex_pc = PCW'(expc); ex_imm = imm;
        ex_alu_result = alu; ex_pred_taken = ept; ex_pred_target = eptg;
    endtask

    // Reference model: table as plain arrays, counters as integers.
    bit          m_val [16];
    int unsigned m_tag [16];
    int unsigned m_tgt [16];
    int          m_ctr [16];
    int unsigned m_cnt;
    bit          m_halted;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_cnt = 0; m_halted = 0;
    endfunction

    function automatic void m_predict(input int unsigned pc, output bit pt, output int unsigned tg);
        int unsigned i;
        i  = (pc / 4) % 16;
        pt = m_val[i] && (m_tag[i] == pc / 64) && (m_ctr[i] >= 2);
        tg = pt ? m_tgt[i] : pc + 4;
    endfunction

    function automatic void m_resolve(input int unsigned ctrl, input int unsigned pc,
                                      input int unsigned imm, input int unsigned alu,
                                      output bit tk, output int unsigned tg);
        tk = 0; tg = pc + imm;
        if (ctrl == 1) tk = alu[0];
        else if (ctrl == 2) tk = 1;
        else if (ctrl == 3) begin tk = 1; tg = alu - (alu % 2); end
    endfunction

    function automatic void m_train(input int unsigned pc, input bit tk, input int unsigned tg);
        int unsigned i;
        i = (pc / 4) % 16;
        if (!(m_val[i] && m_tag[i] == pc / 64)) begin
            m_val[i] = 1; m_tag[i] = pc / 64; m_tgt[i] = tg; m_ctr[i] = tk ? 2 : 1;
        end else if (tk) begin
            m_tgt[i] = tg;
            if (m_ctr[i] < 3) m_ctr[i]++;
        end else if (m_ctr[i] > 0) begin
            m_ctr[i]--;
        end
    endfunction

    initial begin
        bit          pt, tk, misp, ept_r, ev_r, rst_r, hl_r;
        int unsigned ptg, tg, nxt, ifpc_r, expc_r, imm_r, alu_r, eptg_r, ctrl_r;

        // ---------------- directed vectors ----------------
        vecs.push_back(mk(1,0,'h10,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(idle('h10, 0, 'h14, 0, 0, 0));
        vecs.push_back(mk(0,0,'h20,1,1,'h20,'h40,1,0,0,     1,0,'h24,1,'h60,0,0));
        vecs.push_back(idle('h20, 1, 'h60, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,'h20,1,1,'h20,'h40,1,1,'h60, 1,1,'h60,0,0,1,0));
        vecs.push_back(mk(0,0,'h20,1,1,'h20,'h40,0,1,'h60,  1,1,'h60,1,'h24,1,0));
        vecs.push_back(idle('h20, 1, 'h60, 0, 2, 0));
        vecs.push_back(mk(0,0,'h20,1,1,'h20,'h40,0,1,'h60,  1,1,'h60,1,'h24,2,0));
        vecs.push_back(idle('h20, 0, 'h24, 0, 3, 0));
        vecs.push_back(mk(0,0,'h40,1,3,'h40,0,'h107,0,0,    1,0,'h44,1,'h106,3,0));
        vecs.push_back(idle('h40, 1, 'h106, 0, 4, 0));
        vecs.push_back(mk(0,0,'h80,1,2,'h80,'h100,0,1,'h180,1,0,'h84,0,0,4,0));
        vecs.push_back(idle('h80, 1, 'h180, 0, 4, 0));
        vecs.push_back(mk(0,0,'h20,1,1,'h20,'h40,1,0,0,     1,0,'h24,1,'h60,4,0));
        vecs.push_back(idle('h20, 1, 'h60, 0, 5, 0));
        vecs.push_back(mk(0,0,'h20,1,1,'h60,'h10,0,0,0,     1,1,'h60,0,0,5,0));
        vecs.push_back(idle('h20, 0, 'h24, 0, 5, 0));
        vecs.push_back(mk(0,0,'h30,1,0,'h30,0,0,1,'h99,     1,0,'h34,1,'h34,5,0));
        vecs.push_back(idle('h30, 0, 'h34, 0, 6, 0));
        vecs.push_back(mk(0,0,'h20,0,1,'h20,'h40,1,0,0,     1,0,'h24,0,0,6,0));
        vecs.push_back(idle('h20, 0, 'h24, 0, 6, 0));
        vecs.push_back(mk(0,1,'h20,1,1,'h20,'h40,1,0,0,     1,0,'h24,1,'hFFFF_FFFF,6,0));
        vecs.push_back(idle('h20, 0, 'h24, 1, 6, 1));
        vecs.push_back(mk(0,0,'h20,1,1,'h20,'h40,1,0,0,     1,0,'h24,1,'hFFFF_FFFF,6,1));
        vecs.push_back(idle('h20, 0, 'h24, 1, 6, 1));
        vecs.push_back(mk(1,0,'h80,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(idle('h80, 0, 'h84, 0, 0, 0));
        vecs.push_back(mk(1,0,'h80,1,2,'h80,'h100,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(idle('h80, 0, 'h84, 0, 0, 0));

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].hlt_in, vecs[k].ifpc, vecs[k].ev, vecs[k].ctrl,
                  vecs[k].expc, vecs[k].imm, vecs[k].alu, vecs[k].ept, vecs[k].eptg);
            @(negedge clk);
            if (vecs[k].chk) begin
                check($sformatf("v%0d pred_taken", k), 32'(pred_taken), 32'(vecs[k].e_pt));
                check($sformatf("v%0d pred_target", k), pred_target, vecs[k].e_ptg);
                check($sformatf("v%0d redirect", k), 32'(redirect), 32'(vecs[k].e_redir));
                if (vecs[k].e_redir)
                    check($sformatf("v%0d redirect_pc", k), redirect_pc, vecs[k].e_rpc);
                check($sformatf("v%0d pc_plus_4", k), pc_plus_4, vecs[k].expc + 32'd4);
                check($sformatf("v%0d count", k), 32'(mispredict_count), 32'(vecs[k].e_cnt));
                check($sformatf("v%0d halted", k), 32'(halted), 32'(vecs[k].e_halted));
            end
            @(posedge clk); #1;
        end

        // ---------------- counter saturation ----------------
        drive(1,0,0,0,0,0,0,0,0,0);
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            drive(0,0,0,1,0,k*4,0,0,1,0);
            @(negedge clk);
            check($sformatf("sat%0d redirect", k), 32'(redirect), 32'd1);
            check($sformatf("sat%0d count", k), 32'(mispredict_count), (k < 15) ? k : 15);
            @(posedge clk); #1;
        end

        // ---------------- randomized vs model ----------------
        drive(1,0,0,0,0,0,0,0,0,0);
        @(posedge clk); #1;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_r  = (c == 2200) || ($urandom_range(0, 299) == 0);
            hl_r   = (c == 2000) || (c > 2000 && c < 2200 && $urandom_range(0, 9) == 0);
            ifpc_r = $urandom_range(0, 63) * 4;
            expc_r = $urandom_range(0, 63) * 4;
            ev_r   = ($urandom_range(0, 3) != 0);
            ctrl_r = $urandom_range(0, 3);
            imm_r  = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 31) * 4;
            alu_r  = ($urandom_range(0, 1) == 0) ? $urandom() : $urandom_range(0, 511);
            m_predict(expc_r, ept_r, eptg_r);
            if ($urandom_range(0, 9) < 3) begin
                ept_r  = $urandom_range(0, 1);
                eptg_r = ($urandom_range(0, 1) == 0) ? $urandom() : expc_r + imm_r;
            end
            drive(rst_r, hl_r, ifpc_r, ev_r, ctrl_r, expc_r, imm_r, alu_r, ept_r, eptg_r);

            m_predict(ifpc_r, pt, ptg);
            m_resolve(ctrl_r, expc_r, imm_r, alu_r, tk, tg);
            nxt  = tk ? tg : expc_r + 4;
            misp = ev_r && (ctrl_r != 0 || ept_r) && (tk != ept_r || (tk && tg != eptg_r));

            @(negedge clk);
            check("rnd pred_taken", 32'(pred_taken), 32'(pt));
            check("rnd pred_target", pred_target, ptg);
            check("rnd redirect", 32'(redirect), 32'(hl_r || m_halted || misp));
            if (hl_r || m_halted)
                check("rnd redirect_pc halt", redirect_pc, 32'hFFFF_FFFF);
            else if (misp)
                check("rnd redirect_pc", redirect_pc, nxt);
            check("rnd pc_plus_4", pc_plus_4, expc_r + 4);
            check("rnd count", 32'(mispredict_count), m_cnt);
            check("rnd halted", 32'(halted), 32'(m_halted));

            if (rst_r) begin
                m_reset();
            end else begin
                if (!(hl_r || m_halted)) begin
                    if (misp && m_cnt < 15) m_cnt++;
                    if (ev_r && ctrl_r != 0) m_train(expc_r, tk, tg);
                end
                if (hl_r) m_halted = 1;
            end
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
